cordic_freq_disc: RTL and testbench

Phase-difference frequency discriminator that sits directly downstream of the CORDIC vectoring stage. It consumes the CORDIC result stream (amplitude, phase, error flag, valid pulse) and differentiates successive phases with 2π wrap-around. It averages those phase steps over a power-of-two window and reports the mean phase increment per sample, which is the normalized carrier frequency. Weak or erroneous samples are gated out, and loss of lock is flagged.

---
 rtl/cordic_freq_disc.sv | 161 ++++++++++++++++
 tb/tb_cordic_freq_disc.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_freq_disc.sv
// ----------------------------------------------------------------------------
// cordic_freq_disc
//
// Phase-difference frequency discriminator fed by a CORDIC vectoring stage.
// Successive usable phases are differenced modulo 2*pi. The deltas are summed
// over a window of 2^LOG2_WIN deltas, and the mean phase step per sample
// (the normalized carrier frequency) is reported. Weak or erroneous samples
// are gated out. A run of MAX_GAP consecutive unusable samples drops lock.
//
// Ports:
//   sys_clk   in   1            clock, rising edge
//   sys_rst   in   1            synchronous active-high reset
//   ampli_in  in   9            unsigned CORDIC magnitude, Q4.5
//   theta_in  in   10           signed CORDIC phase, LSB = 2*pi/1024
//   err_in    in   1            CORDIC error flag (input was 0,0)
//   vld_in    in   1            qualifies ampli_in / theta_in / err_in
//   clr       in   1            synchronous restart (drops lock and window)
//   freq_out  out  10           signed mean phase step = sum_out >>> LOG2_WIN
//   sum_out   out  10+LOG2_WIN  signed sum of the window's deltas
//   freq_vld  out  1            one-cycle pulse when freq_out/sum_out update
//   lock      out  1            high while tracking (RUN)
//   drop      out  1            one-cycle pulse on gap-induced loss of lock
// ----------------------------------------------------------------------------
module cordic_freq_disc #(
   parameter int LOG2_WIN = 4,
   parameter int AMP_MIN  = 16,
   parameter int MAX_GAP  = 3
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [8:0]            ampli_in,
   input  logic [9:0]            theta_in,
   input  logic                  err_in,
   input  logic                  vld_in,
   input  logic                  clr,
   output logic [9:0]            freq_out,
   output logic [10+LOG2_WIN-1:0] sum_out,
   output logic                  freq_vld,
   output logic                  lock,
   output logic                  drop
);

   localparam int SW = 10 + LOG2_WIN;
   localparam int GW = (MAX_GAP < 2) ? 1 : $clog2(MAX_GAP + 1);
   localparam logic [8:0]    AMP_MIN_V = 9'(AMP_MIN);
   localparam logic [GW-1:0] GAP_LAST  = GW'(MAX_GAP - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [9:0]            prev_q, prev_d;
   logic [SW-1:0]         acc_q, acc_d;
   logic [LOG2_WIN-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic [SW-1:0]         sum_q, sum_d;
   logic [9:0]            freq_q, freq_d;
   logic                  fv_q, fv_d;
   logic                  drop_q, drop_d;

   logic                  usable;
   logic [9:0]            delta;
   logic [SW-1:0]         win_sum;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         prev_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         sum_q   <= '0;
         freq_q  <= '0;
         fv_q    <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         sum_q   <= sum_d;
         freq_q  <= freq_d;
         fv_q    <= fv_d;
         drop_q  <= drop_d;
      end
   end

   // Plain 10-bit subtraction gives the modulo-2*pi delta; the +pi step
   // (512) naturally reads back as -512 in two's complement.
   assign usable  = vld_in && !err_in && (ampli_in >= AMP_MIN_V);
   assign delta   = theta_in - prev_q;
   assign win_sum = acc_q + {{LOG2_WIN{delta[9]}}, delta};

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      gap_d   = gap_q;
      sum_d   = sum_q;
      freq_d  = freq_q;
      fv_d    = 1'b0;
      drop_d  = 1'b0;

      if (clr) begin
         state_d = IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         gap_d   = '0;
      end else if (vld_in) begin
         unique case (state_q)
            IDLE: begin
               if (usable) begin
                  prev_d  = theta_in;
                  state_d = RUN;
                  acc_d   = '0;
                  cnt_d   = '0;
                  gap_d   = '0;
               end
            end
            RUN: begin
               if (usable) begin
                  prev_d = theta_in;
                  gap_d  = '0;
                  if (cnt_q == '1) begin
                     // Top 10 bits of the sum are the arithmetic shift by
                     // LOG2_WIN, i.e. floor toward -inf.
                     sum_d  = win_sum;
                     freq_d = win_sum[LOG2_WIN +: 10];
                     fv_d   = 1'b1;
                     acc_d  = '0;
                     cnt_d  = '0;
                  end else begin
                     acc_d = win_sum;
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (gap_q == GAP_LAST) begin
                  state_d = IDLE;
                  acc_d   = '0;
                  cnt_d   = '0;
                  gap_d   = '0;
                  drop_d  = 1'b1;
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign freq_out = freq_q;
   assign sum_out  = sum_q;
   assign freq_vld = fv_q;
   assign drop     = drop_q;
   assign lock     = (state_q == RUN);

endmodule

// File: tb/tb_cordic_freq_disc.sv
// ----------------------------------------------------------------------------
// tb_cordic_freq_disc
//
// Bench for cordic_freq_disc with default parameters. A behavioural model
// keeps the current window as a queue of deltas and derives the expected
// sum, floored mean, lock and drop from the operating rules.
// ----------------------------------------------------------------------------
module tb_cordic_freq_disc;

   localparam int LOG2_WIN = 4;
   localparam int WIN      = 1 << LOG2_WIN;
   localparam int AMP_MIN  = 16;
   localparam int MAX_GAP  = 3;
   localparam int SW       = 10 + LOG2_WIN;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic [8:0]    ampli_in = '0;
   logic [9:0]    theta_in = '0;
   logic          err_in = 1'b0;
   logic          vld_in = 1'b0;
   logic          clr = 1'b0;
   logic [9:0]    freq_out;
   logic [SW-1:0] sum_out;
   logic          freq_vld;
   logic          lock;
   logic          drop;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit m_lock, m_fv, m_drop;
   int m_prev, m_gap, m_sum, m_freq;
   int win_q[$];

   cordic_freq_disc #(
      .LOG2_WIN (LOG2_WIN),
      .AMP_MIN  (AMP_MIN),
      .MAX_GAP  (MAX_GAP)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .ampli_in (ampli_in),
      .theta_in (theta_in),
      .err_in   (err_in),
      .vld_in   (vld_in),
      .clr      (clr),
      .freq_out (freq_out),
      .sum_out  (sum_out),
      .freq_vld (freq_vld),
      .lock     (lock),
      .drop     (drop)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic int wrap_delta(input int a, input int b);
      int d;
      d = ((a - b) % 1024 + 1024) % 1024;
      if (d >= 512) d -= 1024;
      return d;
   endfunction

   function automatic int floor_div(input int s);
      if (s >= 0) return s / WIN;
      return -((-s + WIN - 1) / WIN);
   endfunction

   task automatic model_reset();
      m_lock = 0; m_fv = 0; m_drop = 0;
      m_prev = 0; m_gap = 0; m_sum = 0; m_freq = 0;
      win_q.delete();
   endtask

   task automatic model_step(input bit v, input int amp, input int th, input bit e, input bit c);
      bit ok;
      int s;
      m_fv = 0;
      m_drop = 0;
      if (c) begin
         m_lock = 0; m_gap = 0; win_q.delete();
         return;
      end
      if (!v) return;
      ok = !e && (amp >= AMP_MIN);
      if (!m_lock) begin
         if (ok) begin
            m_lock = 1; m_prev = th; m_gap = 0; win_q.delete();
         end
      end else if (ok) begin
         win_q.push_back(wrap_delta(th, m_prev));
         m_prev = th;
         m_gap = 0;
         if (win_q.size() == WIN) begin
            s = 0;
            foreach (win_q[i]) s += win_q[i];
            m_sum = s;
            m_freq = floor_div(s);
            m_fv = 1;
            win_q.delete();
         end
      end else begin
         m_gap++;
         if (m_gap == MAX_GAP) begin
            m_lock = 0; m_gap = 0; m_drop = 1; win_q.delete();
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, settle.
   task automatic step(input bit v, input int amp, input int th, input bit e, input bit c);
      @(negedge sys_clk);
      vld_in   = v;
      ampli_in = 9'(amp);
      theta_in = 10'(th);
      err_in   = e;
      clr      = c;
      @(posedge sys_clk);
      model_step(v, amp, th, e, c);
      #1;
      vld_in = 1'b0;
      clr    = 1'b0;
   endtask

   function automatic int sgn10(input int x);
      return ((x + 512) % 1024 + 1024) % 1024 - 512;
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge sys_clk);
         sys_rst  = 1'b1;
         vld_in   = i[0];
         ampli_in = 9'd40;
         theta_in = 10'(i * 37);
         @(posedge sys_clk);
         #1;
         n_tests++;
         if ({freq_vld, lock, drop} !== 3'b000 || sum_out !== '0 || freq_out !== '0) begin
            n_fail++;
            $display("FAIL reset[%0d]: got vld=%0b lock=%0b drop=%0b sum=%0d freq=%0d, want all 0",
                     i, freq_vld, lock, drop, $signed(sum_out), $signed(freq_out));
         end
      end
      @(negedge sys_clk);
      sys_rst = 1'b0;
      vld_in  = 1'b0;
      model_reset();
   endtask

   task automatic test_constant_rotation();
      int nv = 0;
      for (int i = 0; i <= 16; i++) begin
         step(1, 32, i * 10, 0, 0);
         if (freq_vld) nv++;
         n_tests++;
         if ({freq_vld, lock, drop} !== {m_fv, m_lock, m_drop} ||
             sum_out !== SW'(m_sum) || freq_out !== 10'(m_freq)) begin
            n_fail++;
            $display("FAIL rotation[%0d]: got vld=%0b lock=%0b drop=%0b sum=%0d freq=%0d want vld=%0b lock=%0b drop=%0b sum=%0d freq=%0d",
                     i, freq_vld, lock, drop, $signed(sum_out), $signed(freq_out),
                     m_fv, m_lock, m_drop, m_sum, m_freq);
         end
      end
      n_tests++;
      if (nv !== 1 || $signed(sum_out) !== 160 || $signed(freq_out) !== 10) begin
         n_fail++;
         $display("FAIL rotation_result: got pulses=%0d sum=%0d freq=%0d want pulses=1 sum=160 freq=10",
                  nv, $signed(sum_out), $signed(freq_out));
      end
   endtask

   task automatic test_wrap();
      step(0, 0, 0, 0, 1);
      for (int i = 0; i <= 16; i++) step(1, 40, sgn10(500 + 24 * i), 0, 0);
      n_tests++;
      if (freq_vld !== 1'b1 || $signed(freq_out) !== 24 || $signed(sum_out) !== 384) begin
         n_fail++;
         $display("FAIL wrap: got vld=%0b sum=%0d freq=%0d want vld=1 sum=384 freq=24",
                  freq_vld, $signed(sum_out), $signed(freq_out));
      end
   endtask

   task automatic test_floor();
      int th = 100;
      step(0, 0, 0, 0, 1);
      step(1, 32, th, 0, 0);
      for (int i = 0; i < 16; i++) begin
         if (i != 7) th--;
         step(1, 32, th, 0, 0);
      end
      n_tests++;
      if (freq_vld !== 1'b1 || $signed(sum_out) !== -15 || $signed(freq_out) !== -1) begin
         n_fail++;
         $display("FAIL floor: got vld=%0b sum=%0d freq=%0d want vld=1 sum=-15 freq=-1",
                  freq_vld, $signed(sum_out), $signed(freq_out));
      end
   endtask

   task automatic test_weak();
      int k = 0;
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 18; i++) begin
         if (i == 9) step(1, 8, 333, 0, 0);
         else begin
            step(1, 32, k * 5, 0, 0);
            k++;
         end
         n_tests++;
         if ({freq_vld, lock, drop} !== {m_fv, m_lock, m_drop} ||
             sum_out !== SW'(m_sum) || freq_out !== 10'(m_freq)) begin
            n_fail++;
            $display("FAIL weak[%0d]: got vld=%0b lock=%0b drop=%0b sum=%0d freq=%0d want vld=%0b lock=%0b drop=%0b sum=%0d freq=%0d",
                     i, freq_vld, lock, drop, $signed(sum_out), $signed(freq_out),
                     m_fv, m_lock, m_drop, m_sum, m_freq);
         end
      end
      n_tests++;
      if (freq_vld !== 1'b1 || $signed(freq_out) !== 5) begin
         n_fail++;
         $display("FAIL weak_result: got vld=%0b freq=%0d want vld=1 freq=5", freq_vld, $signed(freq_out));
      end
   endtask

   task automatic test_gap();
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(1, 32, i * 7, 0, 0);
      step(1, 8, 50, 0, 0);
      step(1, 0, 60, 1, 0);
      n_tests++;
      if (lock !== 1'b1 || drop !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_hold: got lock=%0b drop=%0b want lock=1 drop=0", lock, drop);
      end
      step(1, 8, 70, 0, 0);
      n_tests++;
      if (drop !== 1'b1 || lock !== 1'b0 || freq_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_drop: got drop=%0b lock=%0b vld=%0b want drop=1 lock=0 vld=0", drop, lock, freq_vld);
      end
      step(1, 32, 300, 0, 0);
      n_tests++;
      if (lock !== 1'b1 || drop !== 1'b0 || freq_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL relock: got lock=%0b drop=%0b vld=%0b want lock=1 drop=0 vld=0", lock, drop, freq_vld);
      end
      for (int i = 1; i <= 16; i++) step(1, 32, 300 + 3 * i, 0, 0);
      n_tests++;
      if (freq_vld !== 1'b1 || $signed(sum_out) !== 48 || $signed(freq_out) !== 3) begin
         n_fail++;
         $display("FAIL reref: got vld=%0b sum=%0d freq=%0d want vld=1 sum=48 freq=3",
                  freq_vld, $signed(sum_out), $signed(freq_out));
      end
   endtask

   task automatic test_clr_collision();
      int held_f, held_s;
      step(0, 0, 0, 0, 1);
      held_f = m_freq;
      held_s = m_sum;
      for (int i = 0; i < 16; i++) step(1, 32, i * 20, 0, 0);
      step(1, 32, 320, 0, 1);
      n_tests++;
      if (freq_vld !== 1'b0 || lock !== 1'b0 || drop !== 1'b0 ||
          $signed(freq_out) !== held_f || $signed(sum_out) !== held_s) begin
         n_fail++;
         $display("FAIL clr_collision: got vld=%0b lock=%0b drop=%0b sum=%0d freq=%0d want vld=0 lock=0 drop=0 sum=%0d freq=%0d",
                  freq_vld, lock, drop, $signed(sum_out), $signed(freq_out), held_s, held_f);
      end
   endtask

   task automatic test_pi_step();
      step(0, 0, 0, 0, 1);
      for (int i = 0; i <= 16; i++) step(1, 64, i[0] ? 0 : -512, 0, 0);
      n_tests++;
      if (freq_vld !== 1'b1 || $signed(sum_out) !== -8192 || $signed(freq_out) !== -512) begin
         n_fail++;
         $display("FAIL pi_step: got vld=%0b sum=%0d freq=%0d want vld=1 sum=-8192 freq=-512",
                  freq_vld, $signed(sum_out), $signed(freq_out));
      end
   endtask

   task automatic test_random();
      int th = 0;
      int rate = 0;
      for (int i = 0; i < 3000; i++) begin
         bit v, e, c;
         int amp;
         if (i % 200 == 0) rate = int'($urandom_range(0, 1023)) - 512;
         v   = ($urandom_range(0, 3) != 0);
         e   = ($urandom_range(0, 15) == 0);
         c   = ($urandom_range(0, 99) == 0);
         amp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(16, 511));
         th  = sgn10(th + rate + int'($urandom_range(0, 6)) - 3);
         step(v, amp, th, e, c);
         n_tests++;
         if ({freq_vld, lock, drop} !== {m_fv, m_lock, m_drop} ||
             sum_out !== SW'(m_sum) || freq_out !== 10'(m_freq)) begin
            n_fail++;
            $display("FAIL random[%0d]: got vld=%0b lock=%0b drop=%0b sum=%0d freq=%0d want vld=%0b lock=%0b drop=%0b sum=%0d freq=%0d",
                     i, freq_vld, lock, drop, $signed(sum_out), $signed(freq_out),
                     m_fv, m_lock, m_drop, m_sum, m_freq);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 16; i++) step(1, 32, i * 9, 0, 0);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      vld_in  = 1'b1;
      ampli_in = 9'd32;
      theta_in = 10'd144;
      @(posedge sys_clk);
      #1;
      model_reset();
      n_tests++;
      if ({freq_vld, lock, drop} !== 3'b000 || sum_out !== '0 || freq_out !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: got vld=%0b lock=%0b drop=%0b sum=%0d freq=%0d want all 0",
                  freq_vld, lock, drop, $signed(sum_out), $signed(freq_out));
      end
      @(negedge sys_clk);
      sys_rst = 1'b0;
      vld_in  = 1'b0;
      step(1, 32, 200, 0, 0);
      n_tests++;
      if (lock !== 1'b1 || freq_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_relock: got lock=%0b vld=%0b want lock=1 vld=0", lock, freq_vld);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_constant_rotation();
      test_wrap();
      test_floor();
      test_weak();
      test_gap();
      test_clr_collision();
      test_pi_step();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
